// File: rtl/fns_cac_enc_seq_if.sv
// ---------------------------------------------------------------------------
// fns_cac_enc_seq_if
// Handshake bundle between a data source, the FNS encoder and the link.
//   datain    : binary data word (source -> encoder)
//   in_valid  : datain is valid (source -> encoder)
//   in_ready  : encoder can accept a word (encoder -> source)
//   codeout   : FNS codeword, bit i carries weight W[i] (encoder -> link)
//   out_valid : codeout is valid (encoder -> link)
//   out_ready : link accepts codeout (link -> encoder)
//   err       : out-of-range input, qualified by out_valid (encoder -> link)
// Modports: master = the side that feeds data in and accepts codewords,
//           slave  = the encoder itself.
// ---------------------------------------------------------------------------
interface fns_cac_enc_seq_if #(
  parameter int N  = 42,
  parameter int DW = 29
) ();
  logic [DW-1:0] datain;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  codeout;
  logic          out_valid;
  logic          out_ready;
  logic          err;

  modport master (
    output datain, in_valid, out_ready,
    input  in_ready, codeout, out_valid, err
  );

  modport slave (
    input  datain, in_valid, out_ready,
    output in_ready, codeout, out_valid, err
  );
endinterface

// File: rtl/fns_cac_enc_seq.sv
// ---------------------------------------------------------------------------
// fns_cac_enc_seq
// Transmit-side Fibonacci-numeral-system crosstalk-avoidance encoder.
// A DW-bit binary word is converted to an N-bit FNS codeword by greedy
// MSB-first subtraction of the weights W[i] (W[0]=1, W[1]=2, Fibonacci
// recurrence above that), one code bit per clock.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : fns_cac_enc_seq_if.slave (datain/in_valid/in_ready on the input
//         side, codeout/out_valid/out_ready/err on the output side)
// Timing: acceptance edge T -> out_valid after edge T+N. A word with
// datain >= W[N] skips the subtraction walk and is reported with err=1 and
// codeout=0 right after the acceptance edge.
// ---------------------------------------------------------------------------
module fns_cac_enc_seq #(
  parameter int N  = 42,
  parameter int DW = 29
) (
  input  logic                clk,
  input  logic                rst,
  fns_cac_enc_seq_if.slave    bus
);

  localparam int IW = $clog2(N);

  // Fibonacci weight W[k], 64-bit, evaluated at elaboration only.
  function automatic logic [63:0] fib_w(input int k);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] t;
    logic [63:0] res;
    a = 64'd1;
    b = 64'd2;
    for (int j = 2; j <= k; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    res = (k == 0) ? a : b;
    return res;
  endfunction

  // First weight that no codeword can reach: anything at or above it is
  // out of range.
  localparam logic [63:0] W_LIMIT = fib_w(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW:0]   r_rem;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_work;      // codeword under construction
  logic [N-1:0]  r_code;      // presented codeword, updated only on DONE entry
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_err;

  // Weight table as constant wires; only indices 0..N-1 exist, so the
  // runtime lookup can never reach W[N] or beyond.
  logic [63:0] w_tab [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_wtab
      localparam logic [63:0] W_I = fib_w(gi);
      assign w_tab[gi] = W_I;
    end
  endgenerate

  logic [63:0]  w_weight;
  logic [63:0]  w_rem64;
  logic [63:0]  w_data64;
  logic [63:0]  w_diff;
  logic         w_take;
  logic         w_oor;
  logic [N-1:0] w_work_next;

  always_comb begin
    w_weight    = w_tab[r_idx];
    w_rem64     = 64'(r_rem);
    w_data64    = 64'(bus.datain);
    w_take      = (w_rem64 >= w_weight);
    w_diff      = w_rem64 - w_weight;
    w_oor       = (w_data64 >= W_LIMIT);
    w_work_next = r_work;
    w_work_next[r_idx] = w_take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_idx       <= '0;
      r_work      <= '0;
      r_code      <= '0;
      r_in_ready  <= 1'b1;   // masked by rst below while reset is held
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_rem      <= {1'b0, bus.datain};
            r_idx      <= IW'(N - 1);
            r_work     <= '0;
            r_in_ready <= 1'b0;
            if (w_oor) begin
              r_state     <= S_DONE;
              r_code      <= '0;
              r_err       <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (w_take) begin
            r_rem <= (DW + 1)'(w_diff);
          end
          r_work <= w_work_next;
          if (r_idx == '0) begin
            r_state     <= S_DONE;
            r_code      <= w_work_next;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  // in_ready is held low for as long as rst is asserted, then comes up in
  // the first cycle after rst falls.
  assign bus.in_ready  = r_in_ready & ~rst;
  assign bus.codeout   = r_code;
  assign bus.out_valid = r_out_valid;
  assign bus.err       = r_err;

endmodule
